dmem_lsu: RTL and testbench

Load/store unit that acts as the initiator on the data-memory port. Accepts one CPU load or store request at a time, splits it into word-granular memory cycles (read-modify-write for byte and halfword stores), and returns an extracted, sign/zero-extended load result or a store completion. Sits between the CPU execute/memory stage and the word-addressed data memory, which reads combinationally and writes on the rising clock edge.

---
 rtl/lsu_defs.sv | 34 +++
 rtl/dmem_lane_merge.sv | 53 +++++
 rtl/dmem_lsu.sv | 111 +++++++++++
 tb/tb_dmem_lsu.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_defs.sv
// Shared definitions for the data-memory load/store unit.
//   LSU_W        : address/data width (32)
//   SZ_*         : request size encodings
//   lsu_state_e  : FSM state encoding
//   misaligned() : alignment/legality check for a size and low address bits
package lsu_defs;

    localparam int unsigned LSU_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRead  = 2'b01,
        StWrite = 2'b10,
        StResp  = 2'b11
    } lsu_state_e;

    // 1 when the request cannot be issued to memory (misaligned or illegal size).
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Combinational byte-lane logic for the load/store unit (little-endian).
//   word_i    : word read from memory (old word for stores, source word for loads)
//   wdata_i   : right-aligned store data
//   size_i    : request size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   addr_lo_i : byte offset within the word
//   signed_i  : loads only, 1 = sign-extend
//   merged_o  : word to write back (addressed lanes replaced; word store = wdata_i)
//   load_o    : extracted and extended load result
module dmem_lane_merge
    import lsu_defs::*;
(
    input  logic [LSU_W-1:0] word_i,
    input  logic [LSU_W-1:0] wdata_i,
    input  logic [1:0]       size_i,
    input  logic [1:0]       addr_lo_i,
    input  logic             signed_i,
    output logic [LSU_W-1:0] merged_o,
    output logic [LSU_W-1:0] load_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word_i[{addr_lo_i, 3'b000} +: 8];
        half_v = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        merged_o = word_i;
        case (size_i)
            SZ_BYTE: merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            SZ_HALF: begin
                if (addr_lo_i[1]) begin
                    merged_o[31:16] = wdata_i[15:0];
                end else begin
                    merged_o[15:0] = wdata_i[15:0];
                end
            end
            default: merged_o = wdata_i;
        endcase
    end

    always_comb begin
        case (size_i)
            SZ_BYTE: load_o = {{24{signed_i & byte_v[7]}}, byte_v};
            SZ_HALF: load_o = {{16{signed_i & half_v[15]}}, half_v};
            SZ_WORD: load_o = word_i;
            default: load_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: initiator on the word-addressed data-memory port.
//   clk, rst (sync, active-high)
//   req_*    : CPU request handshake (valid/ready) and request fields
//   resp_*   : one-cycle completion pulse with load data and error flag
//   DM_CS/DM_R/DM_W, dm_addr, dm_wdata, dm_rdata : data-memory port
// Sub-word stores run read-modify-write: READ captures the old word, WRITE
// sends it back with the addressed lanes replaced.
module dmem_lsu
    import lsu_defs::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [LSU_W-1:0] req_addr,
    input  logic [LSU_W-1:0] req_wdata,
    output logic             resp_valid,
    output logic [LSU_W-1:0] resp_rdata,
    output logic             resp_err,
    output logic             DM_CS,
    output logic             DM_R,
    output logic             DM_W,
    output logic [LSU_W-1:0] dm_addr,
    output logic [LSU_W-1:0] dm_wdata,
    input  logic [LSU_W-1:0] dm_rdata
);

    lsu_state_e       state_q;
    logic             we_q;
    logic [1:0]       size_q;
    logic             signed_q;
    logic [LSU_W-1:0] addr_q;
    logic [LSU_W-1:0] wdata_q;
    logic             err_q;
    logic [LSU_W-1:0] word_q;

    logic [LSU_W-1:0] merged_w;
    logic [LSU_W-1:0] load_w;
    logic             rd_act;
    logic             wr_act;

    dmem_lane_merge u_lane_merge (
        .word_i    (word_q),
        .wdata_i   (wdata_q),
        .size_i    (size_q),
        .addr_lo_i (addr_q[1:0]),
        .signed_i  (signed_q),
        .merged_o  (merged_w),
        .load_o    (load_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            word_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        err_q    <= misaligned(req_size, req_addr[1:0]);
                        if (misaligned(req_size, req_addr[1:0])) begin
                            state_q <= StResp;
                        end else if (req_we && req_size == SZ_WORD) begin
                            state_q <= StWrite;
                        end else begin
                            state_q <= StRead;
                        end
                    end
                end
                StRead: begin
                    word_q  <= dm_rdata;
                    state_q <= we_q ? StWrite : StResp;
                end
                StWrite: state_q <= StResp;
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Everything visible is gated by rst so a reset cycle never strobes memory
    // or completes a request.
    always_comb begin
        rd_act     = (state_q == StRead) && !rst;
        wr_act     = (state_q == StWrite) && !rst;
        req_ready  = (state_q == StIdle) && !rst;
        resp_valid = (state_q == StResp) && !rst;
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !err_q && !we_q) ? load_w : '0;
        DM_CS      = rd_act || wr_act;
        DM_R       = rd_act;
        DM_W       = wr_act;
        dm_addr    = (rd_act || wr_act) ? {addr_q[LSU_W-1:2], 2'b00} : '0;
        dm_wdata   = wr_act ? merged_w : '0;
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed table, reset/handshake sequences,
// randomized requests against a byte-array reference model.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        DM_CS, DM_R, DM_W;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;

    logic [31:0] dmem [64];
    logic [7:0]  rmem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .DM_CS      (DM_CS),
        .DM_R       (DM_R),
        .DM_W       (DM_W),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata)
    );

    assign dm_rdata = dmem[dm_addr[7:2]];

    always @(posedge clk) begin
        if (DM_CS && DM_W) dmem[dm_addr[7:2]] <= dm_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]};
    endfunction

    // Reference: memory as a byte array, results by plain arithmetic.
    task automatic ref_access(input logic we, input logic [1:0] sz, input logic sg,
                              input logic [31:0] ad, input logic [31:0] wd,
                              output logic [31:0] erd, output logic eer, output int elat);
        int     n;
        int     base;
        longint v;
        eer = (sz == 2'b11) || (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00);
        erd = 32'h0;
        elat = 1;
        if (!eer) begin
            n = 1 << sz;
            base = int'(ad[7:0]);
            if (we) begin
                for (int i = 0; i < n; i++) rmem[base+i] = wd[8*i +: 8];
                elat = (n == 4) ? 2 : 3;
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v += longint'(rmem[base+i]) << (8*i);
                if (sg && n < 4 && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
                erd = v[31:0];
                elat = 2;
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int nr, output int nw, output int ncs,
                          output logic [31:0] lwd, output logic [31:0] lad);
        rd = 32'h0; er = 1'b0; lat = -1; nr = 0; nw = 0; ncs = 0; lwd = 32'h0; lad = 32'h0;
        @(negedge clk);
        chk("ready_idle", {31'b0, req_ready}, 32'd1);
        req_we = we; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (DM_R) nr++;
            if (DM_W) begin nw++; lwd = dm_wdata; end
            if (DM_CS) begin ncs++; lad = dm_addr; end
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                break;
            end
        end
    endtask

    task automatic run_check(input string nm, input logic we, input logic [1:0] sz,
                             input logic sg, input logic [31:0] ad, input logic [31:0] wd,
                             output logic [31:0] rd, output logic er, output int lat,
                             output logic [31:0] lwd);
        logic [31:0] erd, lad;
        logic        eer;
        int          elat, nr, nw, ncs, enr, enw;
        ref_access(we, sz, sg, ad, wd, erd, eer, elat);
        do_req(we, sz, sg, ad, wd, rd, er, lat, nr, nw, ncs, lwd, lad);
        enr = (!eer && (!we || sz != 2'b10)) ? 1 : 0;
        enw = (!eer && we) ? 1 : 0;
        chk({nm, "_lat"}, lat, elat);
        chk({nm, "_rdata"}, rd, erd);
        chk({nm, "_err"}, {31'b0, er}, {31'b0, eer});
        chk({nm, "_nrd"}, nr, enr);
        chk({nm, "_nwr"}, nw, enw);
        chk({nm, "_ncs"}, ncs, enr + enw);
        if (!eer) chk({nm, "_dmaddr"}, lad, {ad[31:2], 2'b00});
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_er;
        int          exp_lat;
        logic [31:0] exp_wd;
    } vec_t;

    initial begin
        vec_t        tbl [13];
        logic [31:0] rd, lwd, w;
        logic        er, seen;
        int          lat;

        //         we    sz     sg    addr       wdata          rdata         err  lat wdata-out
        tbl[0]  = '{1'b0, 2'b10, 1'b0, 32'h0C, 32'h0,        32'h8899AABB, 1'b0, 2, 32'h0};
        tbl[1]  = '{1'b0, 2'b00, 1'b1, 32'h0D, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 32'h0};
        tbl[2]  = '{1'b0, 2'b00, 1'b0, 32'h0D, 32'h0,        32'h000000AA, 1'b0, 2, 32'h0};
        tbl[3]  = '{1'b0, 2'b01, 1'b1, 32'h0E, 32'h0,        32'hFFFF8899, 1'b0, 2, 32'h0};
        tbl[4]  = '{1'b0, 2'b01, 1'b0, 32'h0C, 32'h0,        32'h0000AABB, 1'b0, 2, 32'h0};
        tbl[5]  = '{1'b1, 2'b00, 1'b0, 32'h0E, 32'h12345677, 32'h0,        1'b0, 3, 32'h8877AABB};
        tbl[6]  = '{1'b0, 2'b10, 1'b0, 32'h0C, 32'h0,        32'h8877AABB, 1'b0, 2, 32'h0};
        tbl[7]  = '{1'b1, 2'b01, 1'b0, 32'h0D, 32'h5555AAAA, 32'h0,        1'b1, 1, 32'h0};
        tbl[8]  = '{1'b0, 2'b11, 1'b0, 32'h0C, 32'h0,        32'h0,        1'b1, 1, 32'h0};
        tbl[9]  = '{1'b0, 2'b10, 1'b0, 32'h0E, 32'h0,        32'h0,        1'b1, 1, 32'h0};
        tbl[10] = '{1'b0, 2'b10, 1'b0, 32'h0C, 32'h0,        32'h8877AABB, 1'b0, 2, 32'h0};
        tbl[11] = '{1'b0, 2'b00, 1'b1, 32'h0E, 32'h0,        32'h00000077, 1'b0, 2, 32'h0};
        tbl[12] = '{1'b0, 2'b00, 1'b1, 32'h0F, 32'h0,        32'hFFFFFF88, 1'b0, 2, 32'h0};

        for (int i = 0; i < 64; i++) begin
            w = (i == 3) ? 32'h8899AABB : $urandom;
            dmem[i] = w;
            for (int b = 0; b < 4; b++) rmem[4*i+b] = w[8*b +: 8];
        end

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_cs", {29'b0, DM_CS, DM_R, DM_W}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_resp", {30'b0, resp_valid, resp_err}, 32'd0);
        chk("post_rst_rdata", resp_rdata, 32'd0);
        chk("post_rst_strobes", {29'b0, DM_CS, DM_R, DM_W}, 32'd0);
        chk("post_rst_dmaddr", dm_addr, 32'd0);
        chk("post_rst_dmwdata", dm_wdata, 32'd0);

        // Directed table: DUT against both the table constants and the model.
        for (int i = 0; i < 13; i++) begin
            run_check($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].ad,
                      tbl[i].wd, rd, er, lat, lwd);
            chk($sformatf("vec%0d_tbl_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_tbl_err", i), {31'b0, er}, {31'b0, tbl[i].exp_er});
            chk($sformatf("vec%0d_tbl_lat", i), lat, tbl[i].exp_lat);
            if (tbl[i].we && !tbl[i].exp_er)
                chk($sformatf("vec%0d_tbl_dmwdata", i), lwd, tbl[i].exp_wd);
        end
        chk("mem_word3_after_sb", dmem[3], 32'h8877AABB);

        // Reset asserted during the WRITE cycle of a word store.
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h0C;
        req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rstw_dm_w", {31'b0, DM_W}, 32'd0);
        chk("rstw_dm_cs", {31'b0, DM_CS}, 32'd0);
        chk("rstw_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstw_ready_after", {31'b0, req_ready}, 32'd1);
        seen = resp_valid;
        repeat (3) begin
            @(negedge clk);
            seen = seen | resp_valid;
        end
        chk("rstw_no_resp", {31'b0, seen}, 32'd0);
        chk("rstw_word3_kept", dmem[3], 32'h8877AABB);

        // req_valid held high across a store then a load.
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10;
        req_wdata = 32'h01020304; req_valid = 1'b1;
        @(negedge clk);
        chk("held_busy_ready_w", {31'b0, req_ready}, 32'd0);
        chk("held_write_strobe", {31'b0, DM_W}, 32'd1);
        @(negedge clk);
        chk("held_store_resp", {31'b0, resp_valid}, 32'd1);
        for (int b = 0; b < 4; b++) rmem[16+b] = 8'(4 - b);
        req_we = 1'b0;
        @(negedge clk);
        chk("held_ready_idle", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        chk("held_busy_ready_r", {31'b0, req_ready}, 32'd0);
        chk("held_read_strobe", {31'b0, DM_R}, 32'd1);
        @(negedge clk);
        chk("held_load_resp", {31'b0, resp_valid}, 32'd1);
        chk("held_load_rdata", resp_rdata, 32'h01020304);
        req_valid = 1'b0;

        // Randomized requests against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ad;
            logic [1:0]  sz;
            ad = $urandom;
            sz = 2'($urandom_range(0, 3));
            // Bias toward aligned addresses so most requests reach memory.
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) ad[0] = 1'b0;
                if (sz == 2'b10) ad[1:0] = 2'b00;
            end
            run_check($sformatf("rnd%0d", i), 1'($urandom), sz, 1'($urandom), ad, $urandom,
                      rd, er, lat, lwd);
        end

        @(negedge clk);
        for (int i = 0; i < 64; i++) chk($sformatf("mem_word%0d", i), dmem[i], ref_word(i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
